// File: rtl/eq_pkg.sv
// Shared definitions for the slider-pot sequencer: widths, sweep FSM states
// and small helpers for building ADC command words and comparing pot values.
package eq_pkg;

   localparam int POT_W        = 12;
   localparam int SPI_FRAME_W  = 16;
   localparam int ADC_CHAN_W   = 3;
   localparam int CMD_CHAN_LSB = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RD   = 2'd2,
      UPD  = 2'd3
   } state_t;

   // ADC command word: channel number in bits [13:11], everything else zero.
   function automatic logic [SPI_FRAME_W-1:0] mk_cmd(input logic [ADC_CHAN_W-1:0] chan);
      logic [SPI_FRAME_W-1:0] c;
      c = {SPI_FRAME_W{1'b0}};
      c[CMD_CHAN_LSB +: ADC_CHAN_W] = chan;
      return c;
   endfunction

   // Magnitude of the difference between two unsigned pot readings.
   function automatic logic [POT_W-1:0] pot_abs_diff(input logic [POT_W-1:0] a,
                                                     input logic [POT_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/a2d_pot_seq_if.sv
// SPI bus between the pot sequencer (master) and the slider ADC (slave).
interface a2d_pot_seq_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_mstr16.sv
// 16-bit full-duplex SPI frame engine, MSB first, SCLK idles low.
// One frame occupies 18*SCLK_DIV clk cycles: SCLK_DIV/2 lead-in, 16 SCLK
// periods (low half then high half), SCLK_DIV/2 trail, SS_n high SCLK_DIV.
// done is raised two cycles before the frame ends so that a follow-on wrt
// issued on done lands exactly on the last cycle and frames run back to back.
module spi_mstr16 import eq_pkg::*; #(
   parameter int SCLK_DIV = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wrt,
   input  logic [SPI_FRAME_W-1:0] cmd,
   output logic                   done,
   output logic [SPI_FRAME_W-1:0] resp,
   a2d_pot_seq_if.master          spi
);

   localparam int FRM_LEN = 18 * SCLK_DIV;
   localparam int CNT_W   = $clog2(FRM_LEN);
   localparam int DIV_W   = $clog2(SCLK_DIV);
   localparam int HALF    = SCLK_DIV / 2;

   logic                   r_act;
   logic [CNT_W-1:0]       r_cnt;
   logic [DIV_W-1:0]       r_div;
   logic [SPI_FRAME_W-2:0] r_tx;
   logic [SPI_FRAME_W-1:0] r_rx;
   logic                   r_ss_n;
   logic                   r_sclk;
   logic                   r_mosi;
   logic                   r_done;

   logic                   w_last;
   logic                   w_start;
   logic                   w_act_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [DIV_W-1:0]       w_div_nxt;
   logic                   w_sclk_nxt;
   logic                   w_ss_n_nxt;
   logic                   w_rise;
   logic                   w_fall;

   // Next frame position and the SCLK/SS_n levels it implies.
   always_comb begin
      w_last    = r_act && (r_cnt == CNT_W'(FRM_LEN - 1));
      w_start   = wrt && (!r_act || w_last);
      w_act_nxt = w_start || (r_act && !w_last);
      if (w_start) begin
         w_cnt_nxt = {CNT_W{1'b0}};
         w_div_nxt = {DIV_W{1'b0}};
      end else if (r_act) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
         w_div_nxt = (r_div == DIV_W'(SCLK_DIV - 1)) ? {DIV_W{1'b0}} : (r_div + DIV_W'(1));
      end else begin
         w_cnt_nxt = r_cnt;
         w_div_nxt = r_div;
      end
      w_sclk_nxt = w_act_nxt && (w_cnt_nxt >= CNT_W'(SCLK_DIV)) &&
                   (w_cnt_nxt < CNT_W'(17 * SCLK_DIV)) && (w_div_nxt < DIV_W'(HALF));
      w_ss_n_nxt = !(w_act_nxt && (w_cnt_nxt < CNT_W'(17 * SCLK_DIV)));
      w_rise     = w_sclk_nxt && !r_sclk;
      w_fall     = !w_sclk_nxt && r_sclk;
   end

   // Frame counters, registered SPI pins and the shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act  <= 1'b0;
         r_cnt  <= {CNT_W{1'b0}};
         r_div  <= {DIV_W{1'b0}};
         r_tx   <= {(SPI_FRAME_W-1){1'b0}};
         r_rx   <= {SPI_FRAME_W{1'b0}};
         r_ss_n <= 1'b1;
         r_sclk <= 1'b0;
         r_mosi <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_act  <= w_act_nxt;
         r_cnt  <= w_cnt_nxt;
         r_div  <= w_div_nxt;
         r_ss_n <= w_ss_n_nxt;
         r_sclk <= w_sclk_nxt;
         r_done <= r_act && (r_cnt == CNT_W'(FRM_LEN - 3));
         if (w_start) begin
            r_tx   <= cmd[SPI_FRAME_W-2:0];
            r_mosi <= cmd[SPI_FRAME_W-1];
         end else if (w_fall) begin
            r_tx   <= {r_tx[SPI_FRAME_W-3:0], 1'b0};
            r_mosi <= r_tx[SPI_FRAME_W-2];
         end
         if (w_rise) begin
            r_rx <= {r_rx[SPI_FRAME_W-2:0], spi.MISO};
         end
      end
   end

   assign spi.SS_n = r_ss_n;
   assign spi.SCLK = r_sclk;
   assign spi.MOSI = r_mosi;
   assign done     = r_done;
   assign resp     = r_rx;

endmodule

// File: rtl/a2d_pot_seq.sv
// Slider-pot sequencer: sweeps ADC channels 0..NUM_BANDS-1 on each strt and
// keeps one registered 12-bit pot value per band for the band gain scalers.
// Each band takes a command frame then a read frame, because the ADC answers
// with the result of the channel addressed in the previous frame.
// Optional build macro POT_DEADBAND_EN: a slot is only rewritten (and pot_vld
// pulsed) when the new reading differs from the held one by more than
// DEADBAND; the first reading of each slot after reset is always taken.
module a2d_pot_seq import eq_pkg::*; #(
   parameter int NUM_BANDS = 5,
   parameter int SCLK_DIV  = 32
`ifdef POT_DEADBAND_EN
   , parameter int DEADBAND = 4
`endif
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         strt,
   a2d_pot_seq_if.master                spi,
   output logic [POT_W*NUM_BANDS-1:0]   pots,
   output logic                         pot_vld,
   output logic [ADC_CHAN_W-1:0]        band_idx,
   output logic                         busy,
   output logic                         done
);

   state_t                              r_state;
   logic [ADC_CHAN_W-1:0]               r_band;
   logic                                r_wrt;
   logic [SPI_FRAME_W-1:0]              r_cmd;
   logic [NUM_BANDS-1:0][POT_W-1:0]     r_pots;
   logic                                r_pot_vld;
   logic [ADC_CHAN_W-1:0]               r_band_idx;
   logic                                r_busy;
   logic                                r_done;
`ifdef POT_DEADBAND_EN
   logic [NUM_BANDS-1:0]                r_seen;
`endif

   logic                                w_spi_done;
   logic [SPI_FRAME_W-1:0]              w_resp;
   logic [POT_W-1:0]                    w_new;
   logic                                w_accept;
   logic                                w_last_band;
   logic                                w_unused_hi;

   spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
      .clk   (clk),
      .rst_n (rst_n),
      .wrt   (r_wrt),
      .cmd   (r_cmd),
      .done  (w_spi_done),
      .resp  (w_resp),
      .spi   (spi)
   );

   // Decide whether the finished conversion replaces the held slot value.
   always_comb begin
      w_new       = w_resp[POT_W-1:0];
      w_unused_hi = ^w_resp[SPI_FRAME_W-1:POT_W];
      w_last_band = (r_band == ADC_CHAN_W'(NUM_BANDS - 1));
`ifdef POT_DEADBAND_EN
      if (!r_seen[r_band]) begin
         w_accept = 1'b1;
      end else begin
         w_accept = (pot_abs_diff(w_new, r_pots[r_band]) > POT_W'(DEADBAND));
      end
`else
      w_accept = 1'b1;
`endif
   end

   // Sweep FSM with band counter, pot register file and registered status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_band     <= {ADC_CHAN_W{1'b0}};
         r_wrt      <= 1'b0;
         r_cmd      <= {SPI_FRAME_W{1'b0}};
         r_pots     <= {(POT_W*NUM_BANDS){1'b0}};
         r_pot_vld  <= 1'b0;
         r_band_idx <= {ADC_CHAN_W{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef POT_DEADBAND_EN
         r_seen     <= {NUM_BANDS{1'b0}};
`endif
      end else begin
         r_wrt     <= 1'b0;
         r_pot_vld <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               // A strt landing on the done cycle is deliberately dropped.
               if (strt && !r_done) begin
                  r_state <= CMD;
                  r_band  <= {ADC_CHAN_W{1'b0}};
                  r_busy  <= 1'b1;
                  r_wrt   <= 1'b1;
                  r_cmd   <= mk_cmd({ADC_CHAN_W{1'b0}});
               end
            end
            CMD: begin
               if (w_spi_done) begin
                  r_state <= RD;
                  r_wrt   <= 1'b1;
                  r_cmd   <= mk_cmd(r_band);
               end
            end
            RD: begin
               if (w_spi_done) begin
                  r_state <= UPD;
               end
            end
            UPD: begin
               r_band_idx <= r_band;
               if (w_accept) begin
                  r_pots[r_band] <= w_new;
                  r_pot_vld      <= 1'b1;
`ifdef POT_DEADBAND_EN
                  r_seen[r_band] <= 1'b1;
`endif
               end
               if (w_last_band) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= CMD;
                  r_band  <= r_band + ADC_CHAN_W'(1);
                  r_wrt   <= 1'b1;
                  r_cmd   <= mk_cmd(r_band + ADC_CHAN_W'(1));
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign pots     = r_pots;
   assign pot_vld  = r_pot_vld;
   assign band_idx = r_band_idx;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
